// File: rtl/register_pkg.sv
// -----------------------------------------------------------------------------
// register_pkg
// Shared constants and types for enabled_register and its users.
//   DEFAULT_REG_WIDTH : default stored width (the 2-bit {Z, N} status register)
//   STATUS_Z_BIT      : bit position of the zero flag in status_t
//   STATUS_N_BIT      : bit position of the negative flag in status_t
//   status_t          : 2-bit status word, bit1 = Z, bit0 = N
// -----------------------------------------------------------------------------
package register_pkg;

  localparam int DEFAULT_REG_WIDTH = 2;

  localparam int STATUS_Z_BIT = 1;
  localparam int STATUS_N_BIT = 0;

  typedef logic [1:0] status_t;

endpackage : register_pkg

// File: rtl/enabled_register.sv
// -----------------------------------------------------------------------------
// enabled_register
// Parameterised storage register with write enable and synchronous clear.
//
// Parameters:
//   WIDTH       : number of stored bits (1..64), default DEFAULT_REG_WIDTH
//   RESET_VALUE : value loaded by reg_reset
//
// Ports:
//   clock       in   1      rising-edge clock
//   reg_reset   in   1      synchronous active-high clear to RESET_VALUE
//   reg_wr      in   1      write enable, active high
//   reg_in      in   WIDTH  data to store
//   reg_out     out  WIDTH  stored value, straight from flops
//   reg_changed out  1      (only with REGISTER_CHANGE_FLAG_EN) high for one
//                           cycle after a write that altered the stored value
//
// Optional feature macro: REGISTER_CHANGE_FLAG_EN
//
// Handshake: reg_wr acts as a valid qualifier with no ready; the register
// always accepts, and the written value is visible on reg_out one edge later.
// reg_reset has priority over reg_wr on the same edge.
// reg_out is X until the first reset.
// -----------------------------------------------------------------------------
module enabled_register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_REG_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reg_reset,
  input  logic             reg_wr,
  input  logic [WIDTH-1:0] reg_in,
`ifdef REGISTER_CHANGE_FLAG_EN
  output logic             reg_changed,
`endif
  output logic [WIDTH-1:0] reg_out
);

  // Reset / write / hold priority chain.
  always_ff @(posedge clock) begin
    if (reg_reset) begin
      reg_out <= RESET_VALUE;
    end else if (reg_wr) begin
      reg_out <= reg_in;
    end
  end

`ifdef REGISTER_CHANGE_FLAG_EN
  // Compares against the pre-edge reg_out, so the flag marks a real change
  // of stored content; it self-clears on any edge without such a write.
  always_ff @(posedge clock) begin
    if (reg_reset) begin
      reg_changed <= 1'b0;
    end else if (reg_wr) begin
      reg_changed <= (reg_in != reg_out);
    end else begin
      reg_changed <= 1'b0;
    end
  end
`endif

endmodule : enabled_register

// File: tb/tb_enabled_register.sv
// -----------------------------------------------------------------------------
// tb_enabled_register
// Scoreboarded bench for enabled_register: a 2-bit default instance and an
// 8-bit instance with RESET_VALUE 8'hA5, driven together. The driver applies
// inputs on the falling edge, lets the rising edge happen, then pushes the
// value the register must now hold; the monitor pops and compares on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_enabled_register;
  import register_pkg::*;

  localparam logic [7:0] RV8 = 8'hA5;

  // ---------------- clock / reset block ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reg_reset = 1'b0;
  logic       reg_wr    = 1'b0;
  status_t    reg_in    = '0;
  status_t    reg_out;
  logic       reg_reset8 = 1'b0;
  logic       reg_wr8    = 1'b0;
  logic [7:0] reg_in8    = '0;
  logic [7:0] reg_out8;
`ifdef REGISTER_CHANGE_FLAG_EN
  logic       reg_changed;
  logic       reg_changed8;
`endif

  enabled_register u_dut (
    .clock      (clock),
    .reg_reset  (reg_reset),
    .reg_wr     (reg_wr),
    .reg_in     (reg_in),
`ifdef REGISTER_CHANGE_FLAG_EN
    .reg_changed(reg_changed),
`endif
    .reg_out    (reg_out)
  );

  enabled_register #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clock      (clock),
    .reg_reset  (reg_reset8),
    .reg_wr     (reg_wr8),
    .reg_in     (reg_in8),
`ifdef REGISTER_CHANGE_FLAG_EN
    .reg_changed(reg_changed8),
`endif
    .reg_out    (reg_out8)
  );

  // ---------------- scoreboard ----------------
  // Entries are {expected change flag, expected stored value}.
  logic [2:0] exp_q[$];
  logic [8:0] exp8_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model state: what the register should hold.
  status_t    model_val;
  logic [7:0] model_val8;

  // ---------------- driver tasks ----------------
  // One clock edge on both instances; expected results are derived from the
  // register rules: reset wins, else a write stores, else the value is kept.
  task automatic step(input logic rst, input logic wr, input status_t din,
                      input logic rst8, input logic wr8, input logic [7:0] din8);
    logic    chg;
    logic    chg8;
    @(negedge clock);
    reg_reset  = rst;
    reg_wr     = wr;
    reg_in     = din;
    reg_reset8 = rst8;
    reg_wr8    = wr8;
    reg_in8    = din8;
    @(posedge clock);
    chg  = !rst && wr && (din !== model_val);
    chg8 = !rst8 && wr8 && (din8 !== model_val8);
    if (rst) model_val = '0;
    else if (wr) model_val = din;
    if (rst8) model_val8 = RV8;
    else if (wr8) model_val8 = din8;
    exp_q.push_back({chg, model_val});
    exp8_q.push_back({chg8, model_val8});
  endtask

  // Drive the 2-bit instance; the 8-bit one just holds.
  task automatic step2(input logic rst, input logic wr, input status_t din);
    step(rst, wr, din, 1'b0, 1'b0, reg_in8);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [2:0] e;
    logic [8:0] e8;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (reg_out === e[1:0]) passed++;
      else $display("FAIL reg_out: got %b expected %b at %0t", reg_out, e[1:0], $time);
`ifdef REGISTER_CHANGE_FLAG_EN
      checks++;
      if (reg_changed === e[2]) passed++;
      else $display("FAIL reg_changed: got %b expected %b at %0t", reg_changed, e[2], $time);
`endif
    end
    if (exp8_q.size() > 0) begin
      e8 = exp8_q.pop_front();
      checks++;
      if (reg_out8 === e8[7:0]) passed++;
      else $display("FAIL reg_out8: got %h expected %h at %0t", reg_out8, e8[7:0], $time);
`ifdef REGISTER_CHANGE_FLAG_EN
      checks++;
      if (reg_changed8 === e8[8]) passed++;
      else $display("FAIL reg_changed8: got %b expected %b at %0t", reg_changed8, e8[8], $time);
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset both instances; reg_in ignored during reset.
    step(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h3C);
    // Write, then hold while reg_in wiggles.
    step2(1'b0, 1'b1, 2'b01);
    step2(1'b0, 1'b0, 2'b10);
    step2(1'b0, 1'b0, 2'b10);
    // Rewrite the identical value (change flag stays low).
    step2(1'b0, 1'b1, 2'b01);
    // Overwrite.
    step2(1'b0, 1'b1, 2'b10);
    step2(1'b0, 1'b1, 2'b00);
    // Reset beats a simultaneous write.
    step2(1'b0, 1'b1, 2'b10);
    step2(1'b1, 1'b1, 2'b11);
    // Back-to-back writes track reg_in.
    step2(1'b0, 1'b1, 2'b01);
    step2(1'b0, 1'b1, 2'b10);
    step2(1'b0, 1'b1, 2'b11);
    // 8-bit: write then reset back to A5 with a pending write.
    step(1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00);

    // Randomised traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
           status_t'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
           8'($urandom_range(0, 255)));
    end

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && (exp_q.size() > 0 || exp8_q.size() > 0); i++)
      @(posedge clock);
    if (exp_q.size() > 0 || exp8_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d/%0d entries left, required 0", exp_q.size(), exp8_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_enabled_register
